// File: rtl/axi4_master_bridge.sv
// Single-outstanding AXI4 master: turns core memory requests into AXI4 read
// bursts or single-beat writes and returns one registered response per beat.
module axi4_master_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [7:0]            req_len,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_last,
    output logic                  resp_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [ID_W-1:0]       awid,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [ID_W-1:0]       arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_arvalid;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_rdata;
    logic                  r_resp_last;
    logic                  r_resp_err;

    logic w_req_hs;
    logic w_rready;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_resp_accept;
    logic w_last_beat;

    assign req_ready     = (r_state == S_IDLE) && !r_resp_valid;
    assign w_req_hs      = req_valid && req_ready;
    // A new beat may only enter the output register when it is empty or being drained.
    assign w_rready      = (r_state == S_RD_DATA) && (!r_resp_valid || resp_ready);
    assign w_r_hs        = rvalid && w_rready;
    assign w_aw_hs       = r_awvalid && awready;
    assign w_w_hs        = r_wvalid && wready;
    assign w_resp_accept = r_resp_valid && resp_ready;
    assign w_last_beat   = (r_cnt == r_len);

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_last  = r_resp_last;
    assign resp_err   = r_resp_err;

    assign awvalid = r_awvalid;
    assign awaddr  = r_addr;
    assign awid    = '0;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wvalid  = r_wvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign bready  = (r_state == S_WR_RESP);
    assign arvalid = r_arvalid;
    assign araddr  = r_addr;
    assign arid    = '0;
    assign arlen   = r_len;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign rready  = w_rready;

    // Beat counter, not rlast, decides when a burst ends; a wrong rlast is only reported.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_len        <= 8'd0;
            r_cnt        <= 8'd0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_last  <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_resp_accept) begin
                r_resp_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_addr <= req_addr;
                        if (req_wen) begin
                            r_wdata   <= req_wdata;
                            r_wstrb   <= req_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_len     <= req_len;
                            r_cnt     <= 8'd0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= rdata;
                        r_resp_last  <= w_last_beat;
                        r_resp_err   <= (rresp != 2'b00) || (rlast != w_last_beat);
                        r_cnt        <= r_cnt + 8'd1;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_state <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_last  <= 1'b1;
                        r_resp_err   <= (bresp != 2'b00);
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_master_bridge.md
Name: axi4_master_bridge

Overview:
Single-outstanding AXI4 master that converts the core's simple memory request/response interface into AXI4 read bursts and single-beat writes. It sits between the core's memory arbiter and the `io_master_*` port of the top-level core. It is the initiator counterpart of the SoC-side slave memory model.

Parameters:
- ID_W, 4, width of awid/arid; both are driven constant 0.
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Fixed 32: size field is 3'b010, strobe width is 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; must be word-aligned.
- req_len  in  8  read burst beats minus 1; ignored for writes.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write byte strobes.
- resp_valid  out  1  response beat valid.
- resp_ready  in  1  response beat accepted.
- resp_rdata  out  32  read data; 0 for writes.
- resp_last  out  1  final beat of the transaction.
- resp_err  out  1  slave error or burst-length mismatch on this beat.
- awvalid/awready, awaddr[32], awid[ID_W], awlen[8], awsize[3], awburst[2]  AXI write-address channel (out/in/out...).
- wvalid/wready, wdata[32], wstrb[4], wlast  AXI write-data channel.
- bvalid  in  1, bready  out  1, bresp  in  2  AXI write-response channel.
- arvalid/arready, araddr[32], arid[ID_W], arlen[8], arsize[3], arburst[2]  AXI read-address channel.
- rvalid  in  1, rready  out  1, rdata  in  32, rresp  in  2, rlast  in  1  AXI read-data channel.

Behaviour:
- Reset (sampled at a clock edge): state=IDLE; all AXI valid/ready outputs 0; resp_valid=0; resp_last=0; resp_err=0; resp_rdata=0; beat counter 0.
- Reset mid-operation: the bridge abandons the transaction immediately with no drain. The slave is reset together with the bridge.
- Constant outputs: awid=arid=0, awlen=0, awsize=arsize=3'b010, awburst=arburst=2'b01 (INCR), wlast=1.
- req_ready = (state==IDLE) && !resp_valid. Only one transaction is outstanding.
- IDLE:
  - Request accepted with req_wen=0: latch addr and len, clear counter, go to RD_ADDR. arvalid is 1 from the next cycle.
  - Request accepted with req_wen=1: latch addr, data and strb, go to WR_REQ. awvalid and wvalid are both 1 from the next cycle.
- RD_ADDR:
  - arvalid=1; araddr and arlen are held stable.
  - On arvalid && arready, go to RD_DATA.
- RD_DATA:
  - rready = !resp_valid || resp_ready. This gives one registered beat with full throughput.
  - On rvalid && rready, register the response:
    - resp_rdata=rdata.
    - resp_last = (cnt==len).
    - resp_err = (rresp!=0) || (rlast != (cnt==len)).
    - resp_valid=1 in the next cycle.
    - cnt increments.
  - When cnt==len on a handshake, go to IDLE.
  - The beat counter is authoritative. An early rlast is flagged as an error, but the bridge keeps waiting for the remaining beats.
- WR_REQ:
  - awvalid and wvalid each drop the cycle after their own handshake, independently.
  - Both handshakes may occur in the same cycle, or in either order.
  - Once both are done, go to WR_RESP.
  - The bridge never waits for awready before asserting wvalid.
- WR_RESP:
  - bready=1.
  - On bvalid: resp_valid=1, resp_last=1, resp_rdata=0, resp_err=(bresp!=0); go to IDLE.
- Response hold: resp_valid and the resp_* fields hold until resp_ready. resp_valid clears on the accepting edge unless a new beat is captured in the same edge.
- Latency:
  - Read, zero-wait slave: accept at edge T, AR handshake at T+1, first resp_valid at T+3 at the earliest.
  - Write: resp_valid the cycle after the B handshake.
- Address/length values are passed through unmodified. A misaligned req_addr is outside the contract.

Test Plan:
- Single read: addr=0x3000_0000, len=0, slave returns 0xDEADBEEF with rlast=1 → exactly one response beat: resp_rdata=0xDEADBEEF, resp_last=1, resp_err=0; arlen=0; req_ready back to 1 afterward.
- Burst read under backpressure: len=3, slave returns 0x11/0x22/0x33/0x44, resp_ready toggled 1,0,1,0… → exactly 4 beats in order; rready=0 whenever the held beat is unaccepted; resp_last only on 0x44; no beat lost or duplicated.
- Write with independent channels: addr=0xA000_0010, data=0x12345678, strb=4'b0011; slave raises wready 3 cycles before awready → wvalid drops after the W handshake while awvalid stays 1; bready asserted only after both handshakes; bresp=0 → one beat with resp_last=1, resp_err=0.
- Error responses: rresp=2'b10 on beat 1 of a len=1 read → resp_err=1 on that beat only; bresp=2'b11 on a write → resp_err=1.
- Length mismatch: len=2, slave asserts rlast on beat 0 → beat 0 has resp_err=1; the bridge still consumes beats 1 and 2; resp_last=1 on beat 2.
- Reset mid-burst: reset asserted during beat 2 of a len=7 read → at the next edge arvalid=rready=resp_valid=0, req_ready=1 after deassertion; a new read then completes correctly.
